// File: rtl/adc_pkt_pkg.sv
// Shared definitions for the ADC sample packetizer.
//
// Provides the data/counter widths, the header tag and the packetizer
// FSM state type, plus a helper that builds a frame header word.
// Consumers: adc_sample_packetizer_if, adc_pkt_fifo, adc_sample_packetizer.
// The header feature itself is enabled by the ADC_PKT_HEADER_EN macro
// in the top module; this package is the same in both builds.
package adc_pkt_pkg;

   localparam int SAMPLE_W = 16;
   localparam int CNT_W    = 16;

   // Upper nibble of every frame header word.
   localparam logic [3:0] HDR_TAG = 4'hA;

   typedef enum logic {
      HDR  = 1'b0,
      DATA = 1'b1
   } pkt_state_e;

   // Header word: tag in the top nibble, low 12 bits of the frame number.
   function automatic logic [SAMPLE_W-1:0] make_header(input logic [11:0] frame_seq);
      return {HDR_TAG, frame_seq};
   endfunction

endpackage

// File: rtl/adc_sample_packetizer_if.sv
// AXI-Stream style output bundle of the ADC sample packetizer.
//
// Signals:
//   o_Axis_Data  - stream data word
//   o_Axis_Valid - stream valid
//   o_Axis_Last  - last word of a frame
//   i_Axis_Ready - downstream ready
// Modports: master (packetizer side), slave (DMA / consumer side).
interface adc_sample_packetizer_if;
   import adc_pkt_pkg::*;

   logic [SAMPLE_W-1:0] o_Axis_Data;
   logic                o_Axis_Valid;
   logic                o_Axis_Last;
   logic                i_Axis_Ready;

   modport master (
      output o_Axis_Data,
      output o_Axis_Valid,
      output o_Axis_Last,
      input  i_Axis_Ready
   );

   modport slave (
      input  o_Axis_Data,
      input  o_Axis_Valid,
      input  o_Axis_Last,
      output i_Axis_Ready
   );

endinterface

// File: rtl/adc_pkt_fifo.sv
// Synchronous first-word-fall-through sample FIFO.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   wr_en, wr_data  - push request and data (ignored while full)
//   rd_en           - pop request (ignored while empty)
//   rd_data         - word at the head, valid whenever empty is low
//   full, empty     - flags decoded from the registered occupancy
// The caller owns any drop policy; writes into a full FIFO never land.
module adc_pkt_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_fire;
   logic             rd_fire;

   assign full    = (count_q == DEPTH_CNT);
   assign empty   = (count_q == '0);
   assign wr_fire = wr_en && !full;
   assign rd_fire = rd_en && !empty;
   assign rd_data = mem_q[rd_ptr_q];

   // Pointers wrap naturally because the depth is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_fire) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_fire, rd_fire})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/adc_sample_packetizer.sv
// ADC sample packetizer: buffers the free-running sample stream in a small
// FIFO and re-emits it as a back-pressurable stream framed every FRAME_LEN
// samples. Samples arriving while the FIFO is full are dropped and counted.
//
// Ports:
//   i_Clk, i_Rst_L   - clock, asynchronous active-low reset
//   i_Sample_Data    - 16-bit zero-padded ADC sample
//   i_Sample_Valid   - one-cycle strobe per sample
//   o_Sample_Ready   - FIFO not full (informational)
//   axis             - stream output bundle (master modport)
//   i_Clear_Status   - clears o_Overflow and o_Drop_Count
//   o_Overflow       - sticky drop flag
//   o_Drop_Count     - saturating dropped-sample count
//   o_Frame_Count    - completed frames, wrapping
// Build option: ADC_PKT_HEADER_EN prefixes each frame with a header word
// {HDR_TAG, frame_count[11:0]}; without it frames carry data only.
module adc_sample_packetizer
   import adc_pkt_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int FRAME_LEN  = 256
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst_L,
   input  logic [SAMPLE_W-1:0]     i_Sample_Data,
   input  logic                    i_Sample_Valid,
   output logic                    o_Sample_Ready,
   adc_sample_packetizer_if.master axis,
   input  logic                    i_Clear_Status,
   output logic                    o_Overflow,
   output logic [CNT_W-1:0]        o_Drop_Count,
   output logic [CNT_W-1:0]        o_Frame_Count
);

   localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(FRAME_LEN - 1);

   logic                fifo_wr_en;
   logic                fifo_rd_en;
   logic [SAMPLE_W-1:0] fifo_rd_data;
   logic                fifo_full;
   logic                fifo_empty;

   logic [SAMPLE_W-1:0] out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic [CNT_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    frame_count_q, frame_count_d;
   logic [CNT_W-1:0]    drop_count_q, drop_count_d;
   logic                overflow_q, overflow_d;

   logic                handshake;
   logic                load;
   logic                at_last;
   logic                load_hdr;
   logic                drop;

   // Full comes from the registered occupancy, so a pop in the same cycle
   // cannot make room for an incoming sample.
   assign drop       = i_Sample_Valid && fifo_full;
   assign fifo_wr_en = i_Sample_Valid && !fifo_full;

   // The output register refills whenever it is empty or being drained,
   // which sustains one word per cycle.
   assign handshake = out_valid_q && axis.i_Axis_Ready;
   assign load      = !out_valid_q || handshake;

   // idx_q is the frame position of the next data word to be loaded.
   assign at_last = (idx_q == IDX_LAST);

   adc_pkt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SAMPLE_W)
   ) u_fifo (
      .clk     (i_Clk),
      .rst_n   (i_Rst_L),
      .wr_en   (fifo_wr_en),
      .wr_data (i_Sample_Data),
      .rd_en   (fifo_rd_en),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

`ifdef ADC_PKT_HEADER_EN
   pkt_state_e state_q, state_d;

   // Frame state register; the state names what the output register
   // loads next (a header or data words of the current frame).
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q <= HDR;
      end else begin
         state_q <= state_d;
      end
   end

   // A header is only presented once a sample is waiting, and the FSM
   // returns to HDR when the frame's last data word is taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         HDR: begin
            if (load && !fifo_empty) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (load && !fifo_empty && at_last) begin
               state_d = HDR;
            end
         end
         default: state_d = HDR;
      endcase
   end

   assign load_hdr = (state_q == HDR);
`else
   assign load_hdr = 1'b0;
`endif

   // Output register, frame index and status counters. The frame count is
   // updated before the header is built so that a header loaded on the
   // same edge as the previous frame's last handshake carries the new value.
   always_comb begin
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      out_last_d    = out_last_q;
      idx_d         = idx_q;
      frame_count_d = frame_count_q;
      drop_count_d  = drop_count_q;
      overflow_d    = overflow_q;
      fifo_rd_en    = 1'b0;

      if (handshake) begin
         out_valid_d = 1'b0;
         if (out_last_q) begin
            frame_count_d = frame_count_q + CNT_W'(1);
         end
      end

      if (load && !fifo_empty) begin
         out_valid_d = 1'b1;
         if (load_hdr) begin
            out_data_d = make_header(frame_count_d[11:0]);
            out_last_d = 1'b0;
         end else begin
            fifo_rd_en = 1'b1;
            out_data_d = fifo_rd_data;
            out_last_d = at_last;
            idx_d      = at_last ? '0 : idx_q + CNT_W'(1);
         end
      end

      if (i_Clear_Status) begin
         overflow_d   = 1'b0;
         drop_count_d = '0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_count_q != '1) begin
            drop_count_d = drop_count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         idx_q         <= '0;
         frame_count_q <= '0;
         drop_count_q  <= '0;
         overflow_q    <= 1'b0;
      end else begin
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         out_last_q    <= out_last_d;
         idx_q         <= idx_d;
         frame_count_q <= frame_count_d;
         drop_count_q  <= drop_count_d;
         overflow_q    <= overflow_d;
      end
   end

   assign axis.o_Axis_Data  = out_data_q;
   assign axis.o_Axis_Valid = out_valid_q;
   assign axis.o_Axis_Last  = out_last_q;
   assign o_Sample_Ready    = !fifo_full;
   assign o_Overflow        = overflow_q;
   assign o_Drop_Count      = drop_count_q;
   assign o_Frame_Count     = frame_count_q;

endmodule
